// File: rtl/exp3_unidade_controle_if.sv
// Control/status bundle between the Experiência 3 control unit and its datapath.
// The slave side is the control unit; the master side is whoever drives its inputs.
interface exp3_unidade_controle_if;
    logic       iniciar;
    logic       jogada;
    logic       fimC;
    logic       chavesIgualMemoria;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic [3:0] db_estado;

    modport slave (
        input  iniciar, jogada, fimC, chavesIgualMemoria,
        output zeraC, contaC, zeraR, registraR, pronto, acertou, errou, db_estado
    );

    modport master (
        output iniciar, jogada, fimC, chavesIgualMemoria,
        input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou, db_estado
    );
endinterface

// File: rtl/exp3_unidade_controle.sv
// Moore control unit for the Experiência 3 datapath: clears it, registers one
// switch value per play, compares against ROM and ends in success or error.
//
// state      | meaning
// inicial    | idle after reset, waiting for iniciar
// preparacao | clear address counter and switch register
// espera     | waiting for a jogada rising edge
// registra   | load switches into the register
// comparacao | evaluate comparator / terminal count
// proximo    | advance the address counter
// fim_acerto | all 16 entries matched
// fim_erro   | a mismatch ended the sequence
module exp3_unidade_controle (
    input  logic                          clock,
    input  logic                          reset,
    exp3_unidade_controle_if.slave        ctrl
);

    typedef enum logic [3:0] {
        INICIAL    = 4'b0000,
        PREPARACAO = 4'b0001,
        ESPERA     = 4'b0010,
        REGISTRA   = 4'b0100,
        COMPARACAO = 4'b0101,
        PROXIMO    = 4'b0110,
        FIM_ACERTO = 4'b1010,
        FIM_ERRO   = 4'b1110
    } estado_t;

    estado_t estadoAtual;
    estado_t proximoEstado;
    logic    jogadaQ;
    logic    jogadaEv;

    // Only the rising edge of jogada counts, so a held button yields one play.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jogadaQ <= 1'b0;
        end else begin
            jogadaQ <= ctrl.jogada;
        end
    end

    assign jogadaEv = ctrl.jogada & ~jogadaQ;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estadoAtual <= INICIAL;
        end else begin
            estadoAtual <= proximoEstado;
        end
    end

    always_comb begin
        proximoEstado = INICIAL;
        case (estadoAtual)
            INICIAL:    proximoEstado = ctrl.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO: proximoEstado = ESPERA;
            ESPERA:     proximoEstado = jogadaEv ? REGISTRA : ESPERA;
            REGISTRA:   proximoEstado = COMPARACAO;
            COMPARACAO: begin
                // A mismatch wins over the terminal count.
                if (!ctrl.chavesIgualMemoria) begin
                    proximoEstado = FIM_ERRO;
                end else if (ctrl.fimC) begin
                    proximoEstado = FIM_ACERTO;
                end else begin
                    proximoEstado = PROXIMO;
                end
            end
            PROXIMO:    proximoEstado = ESPERA;
            FIM_ACERTO: proximoEstado = ctrl.iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:   proximoEstado = ctrl.iniciar ? PREPARACAO : FIM_ERRO;
            default:    proximoEstado = INICIAL;
        endcase
    end

    always_comb begin
        ctrl.zeraC     = 1'b0;
        ctrl.contaC    = 1'b0;
        ctrl.zeraR     = 1'b0;
        ctrl.registraR = 1'b0;
        ctrl.pronto    = 1'b0;
        ctrl.acertou   = 1'b0;
        ctrl.errou     = 1'b0;
        case (estadoAtual)
            PREPARACAO: begin
                ctrl.zeraC = 1'b1;
                ctrl.zeraR = 1'b1;
            end
            REGISTRA:   ctrl.registraR = 1'b1;
            PROXIMO:    ctrl.contaC    = 1'b1;
            FIM_ACERTO: begin
                ctrl.pronto  = 1'b1;
                ctrl.acertou = 1'b1;
            end
            FIM_ERRO: begin
                ctrl.pronto = 1'b1;
                ctrl.errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl.db_estado = estadoAtual;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// Scoreboard bench for exp3_unidade_controle: each driven cycle queues the
// expected state and outputs, which are popped and compared after the edge.
module tb_exp3_unidade_controle;

    localparam logic [3:0] S_INI  = 4'b0000;
    localparam logic [3:0] S_PREP = 4'b0001;
    localparam logic [3:0] S_ESP  = 4'b0010;
    localparam logic [3:0] S_REG  = 4'b0100;
    localparam logic [3:0] S_COMP = 4'b0101;
    localparam logic [3:0] S_PROX = 4'b0110;
    localparam logic [3:0] S_ACER = 4'b1010;
    localparam logic [3:0] S_ERRO = 4'b1110;

    typedef struct packed {
        logic [3:0] estado;
        logic [6:0] saidas;
    } esperado_t;

    logic clock;
    logic reset;
    exp3_unidade_controle_if ctrlIf ();

    exp3_unidade_controle dut (
        .clock (clock),
        .reset (reset),
        .ctrl  (ctrlIf.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int numRegistra = 0;
    int numConta = 0;
    esperado_t fila[$];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output vector {zeraC, contaC, zeraR, registraR, pronto, acertou, errou}.
    function automatic logic [6:0] saidasDe(input logic [3:0] st);
        case (st)
            S_PREP:  return 7'b1010000;
            S_REG:   return 7'b0001000;
            S_PROX:  return 7'b0100000;
            S_ACER:  return 7'b0000110;
            S_ERRO:  return 7'b0000101;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] saidasDut();
        return {ctrlIf.zeraC, ctrlIf.contaC, ctrlIf.zeraR, ctrlIf.registraR,
                ctrlIf.pronto, ctrlIf.acertou, ctrlIf.errou};
    endfunction

    // Inputs are already set; queue the expectation, clock once, then compare.
    task automatic tick(input logic [3:0] st);
        esperado_t e;
        fila.push_back('{estado: st, saidas: saidasDe(st)});
        @(posedge clock);
        #1;
        if (ctrlIf.registraR) numRegistra++;
        if (ctrlIf.contaC) numConta++;
        if (fila.size() == 0) begin
            checkVal("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = fila.pop_front();
            checkVal("db_estado", 32'(ctrlIf.db_estado), 32'(e.estado));
            checkVal("saidas", 32'(saidasDut()), 32'(e.saidas));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ctrlIf.iniciar = 1'b0;
        ctrlIf.jogada = 1'b0;
        ctrlIf.fimC = 1'b0;
        ctrlIf.chavesIgualMemoria = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkVal("reset_estado", 32'(ctrlIf.db_estado), 32'(S_INI));
        checkVal("reset_saidas", 32'(saidasDut()), 32'd0);
        reset = 1'b0;
        tick(S_INI);
        tick(S_INI);

        // Start, then iniciar is ignored while waiting.
        ctrlIf.iniciar = 1'b1;
        tick(S_PREP);
        ctrlIf.iniciar = 1'b0;
        tick(S_ESP);
        tick(S_ESP);
        ctrlIf.iniciar = 1'b1;
        tick(S_ESP);
        ctrlIf.iniciar = 1'b0;
        tick(S_ESP);

        // One matching, non-final play.
        ctrlIf.jogada = 1'b1;
        tick(S_REG);
        ctrlIf.jogada = 1'b0;
        tick(S_COMP);
        tick(S_PROX);
        tick(S_ESP);

        // Asynchronous reset while in comparacao.
        ctrlIf.jogada = 1'b1;
        tick(S_REG);
        ctrlIf.jogada = 1'b0;
        tick(S_COMP);
        reset = 1'b1;
        #1;
        checkVal("async_reset_estado", 32'(ctrlIf.db_estado), 32'(S_INI));
        checkVal("async_reset_saidas", 32'(saidasDut()), 32'd0);
        #2;
        reset = 1'b0;
        repeat (3) tick(S_INI);

        // Mismatch wins over fimC, error state holds, then restart.
        ctrlIf.iniciar = 1'b1;
        tick(S_PREP);
        ctrlIf.iniciar = 1'b0;
        tick(S_ESP);
        ctrlIf.jogada = 1'b1;
        tick(S_REG);
        ctrlIf.jogada = 1'b0;
        ctrlIf.chavesIgualMemoria = 1'b0;
        ctrlIf.fimC = 1'b1;
        tick(S_COMP);
        repeat (11) tick(S_ERRO);
        ctrlIf.chavesIgualMemoria = 1'b1;
        ctrlIf.fimC = 1'b0;
        ctrlIf.iniciar = 1'b1;
        tick(S_PREP);
        ctrlIf.iniciar = 1'b0;
        tick(S_ESP);

        // Full successful run of 16 plays.
        numRegistra = 0;
        numConta = 0;
        for (int i = 0; i < 16; i++) begin
            ctrlIf.jogada = 1'b1;
            tick(S_REG);
            ctrlIf.jogada = 1'b0;
            ctrlIf.chavesIgualMemoria = 1'b1;
            ctrlIf.fimC = (i == 15);
            tick(S_COMP);
            if (i < 15) begin
                tick(S_PROX);
                tick(S_ESP);
            end else begin
                tick(S_ACER);
            end
        end
        ctrlIf.fimC = 1'b0;
        checkVal("conta_registraR", 32'(numRegistra), 32'd16);
        checkVal("conta_contaC", 32'(numConta), 32'd15);
        tick(S_ACER);
        tick(S_ACER);

        // iniciar held high in a final state restarts at once, then is ignored.
        ctrlIf.iniciar = 1'b1;
        tick(S_PREP);
        tick(S_ESP);
        tick(S_ESP);
        ctrlIf.iniciar = 1'b0;
        tick(S_ESP);

        // jogada held high for 5 cycles gives one play only.
        numRegistra = 0;
        ctrlIf.jogada = 1'b1;
        tick(S_REG);
        tick(S_COMP);
        tick(S_PROX);
        tick(S_ESP);
        tick(S_ESP);
        ctrlIf.jogada = 1'b0;
        tick(S_ESP);
        checkVal("held_jogada_registraR", 32'(numRegistra), 32'd1);
        ctrlIf.jogada = 1'b1;
        tick(S_REG);
        ctrlIf.jogada = 1'b0;
        ctrlIf.chavesIgualMemoria = 1'b0;
        tick(S_COMP);
        tick(S_ERRO);
        checkVal("fila_vazia", 32'(fila.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp3_unidade_controle.md
# exp3_unidade_controle

Moore state machine that sequences the Experiência 3 datapath (`exp3_fluxo_dados`): a 4-bit address counter, a 4-bit switch register, a 16x4 ROM and an equality comparator. It clears the datapath on `iniciar` and registers one switch value per `jogada`. It checks that value against memory, advances the address, and ends in a success or error state. It drives `zeraC`, `contaC`, `zeraR` and `registraR`, and consumes `fimC` and `chavesIgualMemoria`.

## Interface
- No parameters. State encoding is fixed (see Operation).
- `clock`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-high; forces `inicial`.
- `iniciar`  in  1  start request, sampled as a level on rising edges in `inicial`, `fim_acerto` and `fim_erro`.
- `jogada`  in  1  play strobe from the user. Only its rising edge is used, via an internal edge detector.
- `fimC`  in  1  datapath counter terminal count (address = 15).
- `chavesIgualMemoria`  in  1  datapath comparator output.
- `zeraC`  out  1  synchronous clear of the address counter.
- `contaC`  out  1  address counter increment enable.
- `zeraR`  out  1  synchronous clear of the switch register.
- `registraR`  out  1  switch register load enable.
- `pronto`  out  1  sequence finished, in either outcome.
- `acertou`  out  1  all 16 entries matched.
- `errou`  out  1  a mismatch ended the sequence.
- `db_estado`  out  4  current state encoding, for the 7-segment debug display.

## Operation
- Moore FSM: all outputs decode from the state register only. No output is a combinational function of the inputs.
- `jogada_q` flop; the internal play event is `jogada_ev = jogada & ~jogada_q`. `jogada_q` resets to 0 and updates every cycle in all states.
- States and encodings:
  - `inicial` 0000
  - `preparacao` 0001
  - `espera` 0010
  - `registra` 0100
  - `comparacao` 0101
  - `proximo` 0110
  - `fim_acerto` 1010
  - `fim_erro` 1110
- Transitions:
  - `inicial`: `iniciar` -> `preparacao`; else stay.
  - `preparacao`: -> `espera`, unconditionally.
  - `espera`: `jogada_ev` -> `registra`; else stay.
  - `registra`: -> `comparacao`, unconditionally.
  - `comparacao`:
    - `!chavesIgualMemoria` -> `fim_erro`.
    - Otherwise, `fimC` -> `fim_acerto`.
    - Otherwise -> `proximo`.
    - Mismatch takes priority over `fimC`.
  - `proximo`: -> `espera`, unconditionally.
  - `fim_acerto` and `fim_erro`: `iniciar` -> `preparacao`; else stay.
  - Any unused encoding -> `inicial` on the next edge.
- Outputs by state (every output not listed is 0):
  - `preparacao`: `zeraC` = `zeraR` = 1.
  - `registra`: `registraR` = 1.
  - `proximo`: `contaC` = 1.
  - `fim_acerto`: `pronto` = `acertou` = 1.
  - `fim_erro`: `pronto` = `errou` = 1.
- `db_estado` equals the state register at all times.

## Timing
- Reset is asynchronous. While `reset` = 1:
  - state = `inicial`, `jogada_q` = 0.
  - All outputs are 0 and `db_estado` = 0000, immediately and without waiting for a clock edge.
- Reset mid-sequence abandons the sequence. The datapath is not cleared until the next `preparacao`.
- Latencies:
  - `iniciar` high at edge N -> `zeraC`/`zeraR` high during cycle N+1, for exactly 1 cycle.
  - `jogada` rising edge first sampled at edge N while in `espera` -> `registraR` high in cycle N+1. The comparison uses the registered value in cycle N+2.
- The register loads at the edge that leaves `registra`, so `chavesIgualMemoria` in `comparacao` reflects the newly registered switches.
- A match that is not the last entry costs exactly 3 cycles (`registra`, `comparacao`, `proximo`) before returning to `espera`.
- `contaC`, `registraR`, `zeraC` and `zeraR` are each exactly one cycle wide per visit.
- `jogada` held high for any number of cycles produces one play. It must return low for at least 1 cycle before the next play.
- A `jogada` edge that arrives while not in `espera` is lost; it is not queued.
- `iniciar` held high in a final state restarts immediately. `iniciar` in any other state is ignored.
- A full successful run issues 16 `registraR` pulses and 15 `contaC` pulses.

## Test plan
- Reset pulse in `comparacao` (`db_estado` = 0101) -> outputs all 0 and `db_estado` = 0000 before the next clock edge; the FSM holds in `inicial` with `iniciar` = 0.
- `iniciar` = 1 for 1 cycle -> `db_estado` 0001 with `zeraC` = `zeraR` = 1 for one cycle, then 0010 and holds.
- In `espera`, `jogada` 0->1 with `chavesIgualMemoria` = 1, `fimC` = 0 -> `db_estado` sequence 0100 (`registraR` = 1), 0101, 0110 (`contaC` = 1), 0010.
- In `comparacao`, `chavesIgualMemoria` = 0 and `fimC` = 1 -> `fim_erro` (1110) with `pronto` = 1, `errou` = 1, `acertou` = 0. It holds for 10 cycles, and `iniciar` then returns it to 0001.
- 16 plays, all matching, with `fimC` = 1 on the 16th -> `fim_acerto` (1010) with `pronto` = `acertou` = 1. Counted pulses: `registraR` = 16, `contaC` = 15.
- `jogada` held high for 5 cycles in `espera` -> exactly one `registraR` pulse, and the FSM stays in `espera` after `proximo` until a new rising edge.
